udp_decoder: RTL and testbench



---
 rtl/udp_decoder.sv | 105 ++++++++++
 tb/tb_udp_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/udp_decoder.sv
// udp_decoder: parses a UDP datagram word stream, forwards masked payload and verifies the checksum
module udp_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pkg_data,
  input  logic        start,
  input  logic        data_av,
  input  logic [15:0] pseudo_sum,
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [15:0] len_out,
  output logic [31:0] data,
  output logic        wr_en,
  output logic        fin,
  output logic        chk_ok,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, HDR2, PAYLOAD, CHECK} state_t;
  state_t state, state_n;
  logic [31:0] sum, sum_n, data_n, mask, masked;
  logic [15:0] bytes_left, bl_n, rx_chk, rx_chk_n, src_n, dest_n, len_n, len_f, take, f2, folded;
  logic [16:0] f1, t;
  logic wr_n, fin_n, chk_n, err_n, new_dg;
  assign new_dg = start & data_av;
  assign len_f  = pkg_data[31:16];
  assign f1     = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
  assign f2     = f1[15:0] + {15'b0, f1[16]};
  assign t      = {1'b0, f2} + {1'b0, pseudo_sum};
  assign folded = t[15:0] + {15'b0, t[16]};
  assign mask   = (bytes_left > 16'd3) ? '1 :
                  {{8{bytes_left != 16'd0}}, {8{bytes_left > 16'd1}}, {8{bytes_left > 16'd2}}, 8'h00};
  assign masked = pkg_data & mask;
  assign take   = (bytes_left > 16'd3) ? 16'd4 : bytes_left;
  // next-state and next-output computation; a start in CHECK both finishes the old and opens the new datagram
  always_comb begin
    state_n  = state;
    sum_n    = sum;
    bl_n     = bytes_left;
    rx_chk_n = rx_chk;
    src_n    = src_port;
    dest_n   = dest_port;
    len_n    = len_out;
    data_n   = data;
    chk_n    = chk_ok;
    err_n    = err;
    wr_n     = 1'b0;
    fin_n    = 1'b0;
    if (state == CHECK) begin
      fin_n   = 1'b1;
      chk_n   = !err && (rx_chk == 16'h0000 || folded == 16'hFFFF);
      state_n = IDLE;
    end
    if (new_dg) begin
      src_n   = pkg_data[31:16];
      dest_n  = pkg_data[15:0];
      sum_n   = {16'h0, pkg_data[31:16]} + {16'h0, pkg_data[15:0]};
      chk_n   = (state == CHECK) ? chk_n : 1'b0;
      err_n   = (state == CHECK) ? err : 1'b0;
      state_n = HDR2;
    end else if (data_av && state == HDR2) begin
      sum_n    = sum + {16'h0, pkg_data[31:16]} + {16'h0, pkg_data[15:0]};
      rx_chk_n = pkg_data[15:0];
      err_n    = len_f < 16'd8;
      len_n    = (len_f > 16'd8) ? len_f - 16'd8 : 16'd0;
      bl_n     = len_n;
      state_n  = (len_f > 16'd8) ? PAYLOAD : CHECK;
    end else if (data_av && state == PAYLOAD) begin
      data_n  = masked;
      wr_n    = 1'b1;
      sum_n   = sum + {16'h0, masked[31:16]} + {16'h0, masked[15:0]};
      bl_n    = bytes_left - take;
      state_n = (bytes_left <= 16'd4) ? CHECK : PAYLOAD;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sum        <= '0;
      bytes_left <= '0;
      rx_chk     <= '0;
      src_port   <= '0;
      dest_port  <= '0;
      len_out    <= '0;
      data       <= '0;
      wr_en      <= 1'b0;
      fin        <= 1'b0;
      chk_ok     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      sum        <= sum_n;
      bytes_left <= bl_n;
      rx_chk     <= rx_chk_n;
      src_port   <= src_n;
      dest_port  <= dest_n;
      len_out    <= len_n;
      data       <= data_n;
      wr_en      <= wr_n;
      fin        <= fin_n;
      chk_ok     <= chk_n;
      err        <= err_n;
    end
  end
endmodule

// File: tb/tb_udp_decoder.sv
// tb_udp_decoder: scoreboard bench for udp_decoder with directed datagrams
module tb_udp_decoder;
  logic clk = 0, reset, start, data_av, wr_en, fin, chk_ok, err;
  logic [31:0] pkg_data, data;
  logic [15:0] pseudo_sum, src_port, dest_port, len_out;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {
    bit is_fin;
    int cyc;
    logic [31:0] d;
    logic [15:0] src, dest, len;
    logic ok, er;
  } exp_t;
  exp_t q[$];
  exp_t m;

  udp_decoder dut (
    .clk(clk), .reset(reset), .pkg_data(pkg_data), .start(start), .data_av(data_av),
    .pseudo_sum(pseudo_sum), .src_port(src_port), .dest_port(dest_port), .len_out(len_out),
    .data(data), .wr_en(wr_en), .fin(fin), .chk_ok(chk_ok), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, ex);
    end
  endtask

  task automatic push_wr(input logic [31:0] d, input int e);
    exp_t x;
    x.is_fin = 0; x.cyc = e; x.d = d; x.src = 0; x.dest = 0; x.len = 0; x.ok = 0; x.er = 0;
    q.push_back(x);
  endtask

  task automatic push_fin(input int e, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input logic ok, input logic er);
    exp_t x;
    x.is_fin = 1; x.cyc = e; x.d = 0; x.src = s; x.dest = d; x.len = l; x.ok = ok; x.er = er;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] w, input logic s, input int gap, output int e);
    idle(gap);
    pkg_data = w; start = s; data_av = 1;
    @(posedge clk); #1;
    e = cyc;
    data_av = 0; start = 0;
  endtask

  task automatic greet(input logic [15:0] c, input int gap, input logic ok);
    int e;
    send(32'ha08f2694, 1, gap, e);
    send({16'h0013, c}, 0, gap, e);
    send(32'h48656c6c, 0, gap, e); push_wr(32'h48656c6c, e);
    send(32'h6f20576f, 0, gap, e); push_wr(32'h6f20576f, e);
    send(32'h726c64aa, 0, gap, e); push_wr(32'h726c6400, e);
    push_fin(e + 1, 16'ha08f, 16'h2694, 16'h000b, ok, 1'b0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_src"}, src_port, 0);
    chk({tag, "_dest"}, dest_port, 0);
    chk({tag, "_len"}, len_out, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_fin"}, fin, 0);
    chk({tag, "_chk_ok"}, chk_ok, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // monitor: every strobe must match the next scoreboard entry, including the edge it appears on
  always @(negedge clk) begin
    if (wr_en) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr: got data %h want no write", data);
      end else begin
        m = q.pop_front();
        chk("wr_kind", {31'b0, m.is_fin}, 0);
        chk("wr_cycle", cyc, m.cyc);
        chk("wr_data", data, m.d);
      end
    end
    if (fin) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_fin: got fin at cycle %0d want none", cyc);
      end else begin
        m = q.pop_front();
        chk("fin_kind", {31'b0, m.is_fin}, 1);
        chk("fin_cycle", cyc, m.cyc);
        chk("fin_src", src_port, m.src);
        chk("fin_dest", dest_port, m.dest);
        chk("fin_len", len_out, m.len);
        chk("fin_chk_ok", chk_ok, m.ok);
        chk("fin_err", err, m.er);
      end
    end
  end

  initial begin
    int e;
    reset = 1; start = 0; data_av = 0; pkg_data = 0; pseudo_sum = 0;
    idle(2);
    all_zero("reset");
    reset = 0;
    send(32'hdeadbeef, 0, 0, e);
    greet(16'he6fa, 0, 1); idle(3);
    greet(16'he6fa, 2, 1); idle(3);
    greet(16'he6fb, 0, 0);
    greet(16'h0000, 0, 1); idle(3);
    pseudo_sum = 16'h0001;
    greet(16'he6f9, 0, 1); idle(3);
    pseudo_sum = 16'h0000;
    send(32'h12345678, 1, 0, e); send(32'h00080000, 0, 0, e);
    push_fin(e + 1, 16'h1234, 16'h5678, 16'h0000, 1, 0); idle(3);
    send(32'h11112222, 1, 0, e); send(32'h0005abcd, 0, 0, e);
    push_fin(e + 1, 16'h1111, 16'h2222, 16'h0000, 0, 1); idle(3);
    send(32'h00010002, 1, 0, e); send(32'h000e0000, 0, 0, e);
    send(32'hdeadbeef, 0, 0, e); push_wr(32'hdeadbeef, e);
    send(32'hcafef00d, 0, 0, e); push_wr(32'hcafe0000, e);
    push_fin(e + 1, 16'h0001, 16'h0002, 16'h0006, 1, 0);
    send(32'h11111111, 0, 0, e); send(32'h22222222, 0, 0, e); idle(3);
    send(32'h00030004, 1, 0, e); send(32'h000c0000, 0, 0, e);
    send(32'h01020304, 0, 0, e); push_wr(32'h01020304, e);
    push_fin(e + 1, 16'h0003, 16'h0004, 16'h0004, 1, 0); idle(3);
    send(32'h00050006, 1, 0, e); send(32'h00090000, 0, 0, e);
    send(32'habcdef12, 0, 0, e); push_wr(32'hab000000, e);
    push_fin(e + 1, 16'h0005, 16'h0006, 16'h0001, 1, 0); idle(3);
    send(32'ha08f2694, 1, 0, e); send(32'h0013e6fa, 0, 0, e);
    send(32'h48656c6c, 0, 0, e); push_wr(32'h48656c6c, e);
    greet(16'he6fa, 0, 1); idle(3);
    send(32'ha08f2694, 1, 0, e); send(32'h0013e6fa, 0, 0, e);
    send(32'h48656c6c, 0, 0, e); push_wr(32'h48656c6c, e);
    reset = 1;
    idle(1);
    all_zero("midreset");
    reset = 0;
    idle(2);
    greet(16'he6fa, 0, 1); idle(4);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
